// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small circular transmit FIFO.
// The line is driven from a flop and the status outputs are registered.
module uart_tx #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_strb,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       full,
  output logic       busy,
  output logic       overflow
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [BW-1:0]         BAUD_ONE = 1;
  localparam logic [BW-1:0]         BAUD_MAX = BW'(DIV - 1);
  localparam logic [CW-1:0]         CNT_ONE  = 1;
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 4) begin : g_depth_chk
    $error("uart_tx: DEPTH_LOG2 must be within 1..4");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         baud_q;
  logic [2:0]            bit_q;
  logic [7:0]            shift_q;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop, baud_wrap;

  // A write is judged against the registered full flag, so a pop on the
  // same edge never rescues it.
  assign baud_wrap = (baud_q == BAUD_MAX);
  assign push      = wr_strb & ~full;
  assign pop       = (count_q != '0) &
                     ((state_q == IDLE) | ((state_q == STOP) & baud_wrap));

  // Occupancy after this edge; push+pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  // Frame sequencing: STOP chains straight into START when data is waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = START;
      START:   if (baud_wrap) state_d = DATA;
      DATA:    if (baud_wrap && bit_q == 3'd7) state_d = STOP;
      STOP:    if (baud_wrap) state_d = pop ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage; no reset needed since the count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  // FIFO pointers, count and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count_q  <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      count_q <= count_d;
      full    <= (count_d == CNT_FULL);
      // A drop on the same edge as a clear keeps the flag set.
      if (wr_strb && full) overflow <= 1'b1;
      else if (ovf_clr)    overflow <= 1'b0;
    end
  end

  // Transmit FSM with baud counter, shifter and registered line/busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE) || (count_d != '0);
      case (state_q)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_q[0];
        default: tx <= 1'b1;
      endcase
      if (pop) begin
        baud_q  <= '0;
        bit_q   <= '0;
        shift_q <= mem[rptr];
      end else if (state_q != IDLE) begin
        baud_q <= baud_wrap ? '0 : baud_q + BAUD_ONE;
        if (state_q == DATA && baud_wrap) begin
          shift_q <= {1'b0, shift_q[7:1]};
          bit_q   <= bit_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scenario tasks against a frame-timing reference model and a
// serial-line decoder.
module tb_uart_tx;

  localparam int DIV   = 8;
  localparam int FRAME = 10 * DIV;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_strb = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx, full, busy, overflow;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  uart_tx #(.CLK_FREQ(8), .BAUD(1), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_strb(wr_strb),
    .ovf_clr(ovf_clr), .tx(tx), .full(full), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: each accepted byte gets a pop edge; frames are FRAME
  // cycles long and a byte pops at the later of (write+1) or the end of the
  // previous frame. Occupancy before edge e = accepted bytes popping at >= e.
  int         m_pop[$];
  logic [7:0] m_dat[$];
  logic       m_ovf = 1'b0;

  function automatic void m_edge(int e, logic w, logic [7:0] d, logic clr);
    int n = 0;
    int p;
    foreach (m_pop[i]) if (m_pop[i] >= e) n++;
    if (w && n >= DEPTH) m_ovf = 1'b1;
    else begin
      if (clr) m_ovf = 1'b0;
      if (w) begin
        p = e + 1;
        if (m_pop.size() > 0 && m_pop[m_pop.size()-1] + FRAME > p)
          p = m_pop[m_pop.size()-1] + FRAME;
        m_pop.push_back(p);
        m_dat.push_back(d);
      end
    end
  endfunction

  function automatic logic m_full(int e);
    int n = 0;
    foreach (m_pop[i]) if (m_pop[i] > e) n++;
    return n == DEPTH;
  endfunction

  function automatic logic m_busy(int e);
    return m_pop.size() > 0 && m_pop[m_pop.size()-1] + FRAME > e;
  endfunction

  function automatic void m_clear();
    m_pop.delete();
    m_dat.delete();
    m_ovf = 1'b0;
  endfunction

  // Line decoder: samples mid-bit, records byte and cycle of the first low.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         rx_bad = 0;
  logic       mon_on = 1'b0;
  int         mon_t0 = 0;
  int         mon_k;
  logic [7:0] mon_b = 8'h00;

  always @(negedge clk) begin
    if (!reset) mon_on = 1'b0;
    else if (!mon_on) begin
      if (tx === 1'b0) begin
        mon_on = 1'b1;
        mon_t0 = cyc;
      end
    end else begin
      mon_k = cyc - mon_t0;
      if (mon_k % DIV == DIV / 2) begin
        if (mon_k / DIV == 0) begin
          if (tx !== 1'b0) begin rx_bad++; mon_on = 1'b0; end
        end else if (mon_k / DIV <= 8) begin
          mon_b[mon_k / DIV - 1] = tx;
        end else begin
          if (tx !== 1'b1) rx_bad++;
          rx_q.push_back(mon_b);
          rx_t.push_back(mon_t0);
          mon_on = 1'b0;
        end
      end
    end
  end

  // One clock of stimulus: inputs for the next edge, then wait past it.
  task automatic cycle(input logic w, input logic [7:0] d, input logic clr);
    wr_strb = w;
    wr_data = d;
    ovf_clr = clr;
    m_edge(cyc + 1, w, d, clr);
    @(negedge clk);
    wr_strb = 1'b0;
    ovf_clr = 1'b0;
  endtask

  // Idle until the model says the line has gone quiet (bounded by the model).
  task automatic drain();
    int lim = cyc + 2000;
    while (m_busy(cyc) && cyc < lim) cycle(1'b0, 8'h00, 1'b0);
    repeat (4) cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_strb = (i % 2 == 0);
      wr_data = 8'h5A;
      @(negedge clk);
      tests++;
      if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: tx=%b busy=%b full=%b ovf=%b, want 1 0 0 0", tx, busy, full, overflow);
      end
    end
    wr_strb = 1'b0;
    reset = 1'b1;
    m_clear();
    rx_q.delete(); rx_t.delete();
    repeat (12) cycle(1'b0, 8'h00, 1'b0);
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || rx_q.size() != 0) begin
      fails++;
      $display("FAIL reset_release: tx=%b busy=%b frames=%0d, want 1 0 0", tx, busy, rx_q.size());
    end
  endtask

  task automatic test_single();
    int n;
    logic [9:0] fr;
    logic e;
    rx_q.delete(); rx_t.delete();
    fr = {1'b1, 8'hA5, 1'b0};
    cycle(1'b1, 8'hA5, 1'b0);
    n = cyc;
    for (int k = 1; k <= 84; k++) begin
      cycle(1'b0, 8'h00, 1'b0);
      e = (k < 2 || k >= 82) ? 1'b1 : fr[(k - 2) / DIV];
      tests++;
      if (tx !== e) begin
        fails++;
        $display("FAIL single_tx: edge N+%0d tx=%b, want %b", k, tx, e);
      end
      if (k == 80 || k == 82) begin
        tests++;
        if (busy !== (k == 80)) begin
          fails++;
          $display("FAIL single_busy: edge N+%0d busy=%b, want %b", k, busy, k == 80);
        end
      end
    end
    tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5 || rx_t[0] != n + 2) begin
      fails++;
      $display("FAIL single_rx: frames=%0d byte=%h start=%0d, want 1 a5 %0d",
               rx_q.size(), rx_q.size() ? rx_q[0] : 8'hxx, rx_t.size() ? rx_t[0] : -1, n + 2);
    end
  endtask

  task automatic test_fill_overflow();
    int s;
    rx_q.delete(); rx_t.delete();
    s = cyc;
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      if (i == 5) begin
        tests++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          fails++;
          $display("FAIL fill_full: full=%b ovf=%b, want 1 0", full, overflow);
        end
      end
    end
    tests++;
    if (full !== 1'b1 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL fill_drop: full=%b ovf=%b, want 1 1", full, overflow);
    end
    cycle(1'b1, 8'h07, 1'b1);
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set_wins: ovf=%b, want 1", overflow);
    end
    cycle(1'b0, 8'h00, 1'b1);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: ovf=%b, want 0", overflow);
    end
    drain();
    tests++;
    if (rx_q.size() != 5) begin
      fails++;
      $display("FAIL fill_count: frames=%0d, want 5", rx_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < 5; i++) begin
      tests++;
      if (rx_q[i] !== 8'(i + 1) || rx_t[i] != s + 3 + FRAME * i) begin
        fails++;
        $display("FAIL fill_stream: frame %0d byte=%h start=%0d, want %h %0d",
                 i, rx_q[i], rx_t[i], 8'(i + 1), s + 3 + FRAME * i);
      end
    end
  endtask

  task automatic test_push_pop();
    int s;
    logic [7:0] b[7];
    rx_q.delete(); rx_t.delete();
    for (int i = 0; i < 7; i++) b[i] = 8'($urandom);
    s = cyc;
    for (int i = 0; i < 5; i++) cycle(1'b1, b[i], 1'b0);
    while (cyc < s + 81) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, ~b[0], 1'b0);              // stop->start edge while full
    tests++;
    if (overflow !== 1'b1 || full !== 1'b0) begin
      fails++;
      $display("FAIL pp_full_reject: ovf=%b full=%b, want 1 0", overflow, full);
    end
    cycle(1'b0, 8'h00, 1'b1);
    while (cyc < s + 161) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, b[5], 1'b0);               // push + pop with three queued
    tests++;
    if (full !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL pp_same_edge: full=%b ovf=%b, want 0 0", full, overflow);
    end
    cycle(1'b1, b[6], 1'b0);
    tests++;
    if (full !== 1'b1) begin
      fails++;
      $display("FAIL pp_count3: full=%b, want 1", full);
    end
    drain();
    tests++;
    if (rx_q.size() != 7) begin
      fails++;
      $display("FAIL pp_count: frames=%0d, want 7", rx_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < 7; i++) begin
      tests++;
      if (rx_q[i] !== b[i] || rx_t[i] != s + 3 + FRAME * i) begin
        fails++;
        $display("FAIL pp_order: frame %0d byte=%h start=%0d, want %h %0d",
                 i, rx_q[i], rx_t[i], b[i], s + 3 + FRAME * i);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    rx_q.delete(); rx_t.delete();
    cycle(1'b1, 8'h3C, 1'b0);
    n = cyc;
    cycle(1'b1, 8'h81, 1'b0);
    cycle(1'b1, 8'h42, 1'b0);
    while (cyc < n + 45) cycle(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin
      fails++;
      $display("FAIL midframe_abort: tx=%b busy=%b full=%b, want 1 0 0", tx, busy, full);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_clear();
    repeat (20) cycle(1'b0, 8'h00, 1'b0);
    tests++;
    if (rx_q.size() != 0 || busy !== 1'b0 || tx !== 1'b1) begin
      fails++;
      $display("FAIL midframe_flushed: frames=%0d busy=%b tx=%b, want 0 0 1", rx_q.size(), busy, tx);
    end
    cycle(1'b1, 8'h55, 1'b0);
    n = cyc;
    cycle(1'b0, 8'h00, 1'b0);
    tests++;
    if (tx !== 1'b1) begin
      fails++;
      $display("FAIL midframe_lat1: tx=%b at N+1, want 1", tx);
    end
    cycle(1'b0, 8'h00, 1'b0);
    tests++;
    if (tx !== 1'b0) begin
      fails++;
      $display("FAIL midframe_lat2: tx=%b at N+2, want 0", tx);
    end
    drain();
    tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55 || rx_t[0] != n + 2) begin
      fails++;
      $display("FAIL midframe_rx: frames=%0d byte=%h start=%0d, want 1 55 %0d",
               rx_q.size(), rx_q.size() ? rx_q[0] : 8'hxx, rx_t.size() ? rx_t[0] : -1, n + 2);
    end
  endtask

  task automatic test_random();
    logic w, clr;
    int pct;
    rx_q.delete(); rx_t.delete();
    m_clear();
    rx_bad = 0;
    for (int i = 0; i < 2000; i++) begin
      pct = ((i / 250) % 2 == 1) ? 40 : 6;
      w   = ($urandom_range(0, 99) < pct);
      clr = ($urandom_range(0, 39) == 0);
      cycle(w, 8'($urandom), clr);
      tests++;
      if (full !== m_full(cyc) || busy !== m_busy(cyc) || overflow !== m_ovf) begin
        fails++;
        $display("FAIL rand_status: edge %0d full=%b busy=%b ovf=%b, want %b %b %b",
                 cyc, full, busy, overflow, m_full(cyc), m_busy(cyc), m_ovf);
      end
    end
    drain();
    tests++;
    if (rx_q.size() != m_dat.size() || rx_bad != 0) begin
      fails++;
      $display("FAIL rand_count: frames=%0d bad=%0d, want %0d 0", rx_q.size(), rx_bad, m_dat.size());
    end
    for (int i = 0; i < rx_q.size() && i < m_dat.size(); i++) begin
      tests++;
      if (rx_q[i] !== m_dat[i] || rx_t[i] != m_pop[i] + 1) begin
        fails++;
        $display("FAIL rand_stream: frame %0d byte=%h start=%0d, want %h %0d",
                 i, rx_q[i], rx_t[i], m_dat[i], m_pop[i] + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_push_pop();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
